vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/vga_sync_gen.sv | 127 ++++++++++++
 tb/tb_vga_sync_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the VGA timing generator, the frame compositor and the DAC pins.
// pix_tick and frame_start are single-clk strobes with no valid/ready handshake: the consumer must sample them every clk.
interface vga_sync_gen_if;
  logic [7:0] rgb_in;
  logic [9:0] x_ptr;
  logic [9:0] y_ptr;
  logic       pix_tick;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [7:0] rgb_out;

  modport master (
    input  rgb_in,
    output x_ptr, y_ptr, pix_tick, frame_start, hsync, vsync, video_on, rgb_out
  );

  modport slave (
    output rgb_in,
    input  x_ptr, y_ptr, pix_tick, frame_start, hsync, vsync, video_on, rgb_out
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, H/V counters, sync/blank decode delayed by PIPE_DLY,
// and RGB blanking outside the visible area.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [3:0] div;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       fs_q;
  logic       pix_tick;
  logic       hs_raw;
  logic       vs_raw;
  logic       von_raw;
  logic       hs_d;
  logic       vs_d;
  logic       von_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // With CLK_DIV=1 the divider sits at 0 and the tick is permanently high.
  assign pix_tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      fs_q <= pix_tick && (x_q == H_LAST) && (y_q == V_LAST);
      if (pix_tick) begin
        if (x_q == H_LAST) begin
          x_q <= '0;
          if (y_q == V_LAST) begin
            y_q <= '0;
          end else begin
            y_q <= y_q + 10'd1;
          end
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hs_raw  = !((x_q >= H_SYNC_START) && (x_q < H_SYNC_END));
    vs_raw  = !((y_q >= V_SYNC_START) && (y_q < V_SYNC_END));
    von_raw = (x_q < H_VIS) && (y_q < V_VIS);
  end

  // Delay line aligning sync/blank with the compositor's registered RGB.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hs_d  = hs_raw;
      assign vs_d  = vs_raw;
      assign von_d = von_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr;
      logic [PIPE_DLY-1:0] vs_sr;
      logic [PIPE_DLY-1:0] von_sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hs_sr  <= '1;
          vs_sr  <= '1;
          von_sr <= '0;
        end else begin
          hs_sr[0]  <= hs_raw;
          vs_sr[0]  <= vs_raw;
          von_sr[0] <= von_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
            von_sr[i] <= von_sr[i-1];
          end
        end
      end

      assign hs_d  = hs_sr[PIPE_DLY-1];
      assign vs_d  = vs_sr[PIPE_DLY-1];
      assign von_d = von_sr[PIPE_DLY-1];
    end
  endgenerate

  assign bus.x_ptr       = x_q;
  assign bus.y_ptr       = y_q;
  assign bus.pix_tick    = pix_tick;
  assign bus.frame_start = fs_q;
  assign bus.hsync       = hs_d;
  assign bus.vsync       = vs_d;
  assign bus.video_on    = von_d;
  assign bus.rgb_out     = von_d ? bus.rgb_in : 8'h00;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-geometry instances (divided/delayed and undivided/undelayed)
// compared every clk against a model that derives all outputs from the clk count since reset release.
module tb_vga_sync_gen;
  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HV + HFP + HSW + HBP;
  localparam int VT  = VV + VFP + VSW + VBP;

  localparam int A_DIV = 4;
  localparam int A_DLY = 2;
  localparam int B_DIV = 1;
  localparam int B_DLY = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       von;
    logic [7:0] rgb;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic clk;
  logic rst_n;
  int   t;
  int   total;
  int   bad;
  logic [W-1:0] exp_q[$];

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();

  vga_sync_gen #(
    .CLK_DIV(A_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIPE_DLY(A_DLY)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_a)
  );

  vga_sync_gen #(
    .CLK_DIV(B_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .PIPE_DLY(B_DLY)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: t = rising edges since reset release; p = completed pixel periods.
  function automatic obs_t model(input int div, input int dly, input int tt, input logic [7:0] rgb);
    obs_t o;
    int p, td, pd, xd, yd;
    p      = tt / div;
    o.x    = 10'(p % HT);
    o.y    = 10'((p / HT) % VT);
    o.tick = ((tt % div) == (div - 1));
    o.fs   = (p > 0) && ((p % (HT * VT)) == 0) && ((tt % div) == 0);
    td     = tt - dly;
    if (td < 0) begin
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.von = 1'b0;
    end else begin
      pd    = td / div;
      xd    = pd % HT;
      yd    = (pd / HT) % VT;
      o.hs  = !((xd >= HV + HFP) && (xd < HV + HFP + HSW));
      o.vs  = !((yd >= VV + VFP) && (yd < VV + VFP + VSW));
      o.von = (xd < HV) && (yd < VV);
    end
    o.rgb = o.von ? rgb : 8'h00;
    return o;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic compare(input string name, input obs_t got);
    obs_t e;
    e = obs_t'(exp_q.pop_front());
    check({name, ".x_ptr"},       int'(got.x),    int'(e.x));
    check({name, ".y_ptr"},       int'(got.y),    int'(e.y));
    check({name, ".pix_tick"},    int'(got.tick), int'(e.tick));
    check({name, ".frame_start"}, int'(got.fs),   int'(e.fs));
    check({name, ".hsync"},       int'(got.hs),   int'(e.hs));
    check({name, ".vsync"},       int'(got.vs),   int'(e.vs));
    check({name, ".video_on"},    int'(got.von),  int'(e.von));
    check({name, ".rgb_out"},     int'(got.rgb),  int'(e.rgb));
  endtask

  // scoreboard: push model for both instances, then compare observations in order
  task automatic sample();
    obs_t oa, ob;
    exp_q.push_back(W'(model(A_DIV, A_DLY, t, bus_a.rgb_in)));
    exp_q.push_back(W'(model(B_DIV, B_DLY, t, bus_b.rgb_in)));
    oa = '{bus_a.x_ptr, bus_a.y_ptr, bus_a.pix_tick, bus_a.frame_start,
           bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.rgb_out};
    ob = '{bus_b.x_ptr, bus_b.y_ptr, bus_b.pix_tick, bus_b.frame_start,
           bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.rgb_out};
    compare("a", oa);
    compare("b", ob);
  endtask

  // driver: one clk, new random pixel data, sample between edges
  task automatic step();
    @(posedge clk);
    if (rst_n) t++;
    @(negedge clk);
    bus_a.rgb_in = 8'($urandom_range(0, 255));
    bus_b.rgb_in = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom_range(0, 255));
    #1;
    sample();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset is asserted between edges and checked before any clk edge to prove it is asynchronous.
  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    t     = 0;
    #1;
    sample();
    run(hold);
    rst_n = 1'b1;
    #1;
    sample();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    t            = 0;
    bus_a.rgb_in = 8'h00;
    bus_b.rgb_in = 8'h00;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    @(negedge clk);
    #1;
    sample();
    run(3);
    rst_n = 1'b1;
    #1;
    sample();
    // two full frames of the slow instance, so frame_start spacing and wrap are covered
    run(2 * HT * VT * A_DIV + 50);
    for (int k = 0; k < 4; k++) begin
      pulse_reset(int'($urandom_range(1, 5)));
      run(int'($urandom_range(30, HT * VT * A_DIV - 1)));
    end
    // last reset lands mid-frame; run past one frame to see frame_start after reset
    pulse_reset(2);
    run(HT * VT * A_DIV + 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
